// File: rtl/inst_fetch.sv
// Instruction-fetch unit: PC, loadable instruction memory, start/run/halt control
// and retired-instruction counter feeding the single-cycle decoder.
module inst_fetch #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INST  = 32'h0000_000C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  jump,
  input  logic                  branch,
  input  logic                  zero,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic [31:0]           inst,
  output logic [31:0]           pc,
  output logic                  inst_valid,
  output logic                  halted,
  output logic [31:0]           retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] index;
  logic [31:0]           fetched;
  logic [31:0]           pc_plus4;
  logic [31:0]           branch_off;
  logic [31:0]           next_pc;
  logic                  advance;
  logic                  is_halt;

  // Memory has no reset so a loaded program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign index      = pc[ADDR_WIDTH+1:2];
  assign fetched    = mem[index];
  assign inst       = inst_valid ? fetched : 32'h0;
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{fetched[15]}}, fetched[15:0], 2'b00};
  assign advance    = (state == RUN) && !stall;
  assign is_halt    = (fetched == HALT_INST);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], fetched[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (!stall && is_halt) next_state = HALT;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    inst_valid = (state == RUN);
    halted     = (state == HALT);
  end

  // The halt word retires but holds the PC on itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      retired <= 32'd0;
    end else if (advance) begin
      retired <= retired + 32'd1;
      if (!is_halt) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: sequencing, jump/branch, stall,
// reset behaviour and IDLE/HALT immunity.
module tb_inst_fetch;

  localparam int          AW   = 6;
  localparam logic [31:0] HALT = 32'h0000_000C;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stall;
  logic          jump;
  logic          branch;
  logic          zero;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   inst;
  logic [31:0]   pc;
  logic          inst_valid;
  logic          halted;
  logic [31:0]   retired;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.ADDR_WIDTH(AW), .RESET_PC(32'h0), .HALT_INST(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .inst(inst), .pc(pc), .inst_valid(inst_valid),
    .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Reset pulse placed between edges; caller is 1 time unit after a posedge.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    chk("reset_pc", pc, 32'h0);
    chk("reset_retired", retired, 32'h0);
    chk("reset_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    chk("reset_inst", inst, 32'h0);
    rst = 1'b1;
    step();
    chk("idle_pc", pc, 32'h0);
    chk("idle_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  task automatic test_sequential();
    load_word(0, 32'h2008_0005);
    load_word(1, 32'h2009_0003);
    load_word(2, HALT);
    do_reset();
    start_run();
    chk("seq_pc0", pc, 32'd0);
    chk("seq_inst0", inst, 32'h2008_0005);
    chk("seq_valid0", {31'b0, inst_valid}, 32'd1);
    step();
    chk("seq_pc1", pc, 32'd4);
    chk("seq_inst1", inst, 32'h2009_0003);
    step();
    chk("seq_pc2", pc, 32'd8);
    chk("seq_inst2", inst, HALT);
    step();
    chk("seq_halted", {31'b0, halted}, 32'd1);
    chk("seq_valid_h", {31'b0, inst_valid}, 32'd0);
    chk("seq_retired", retired, 32'd3);
    chk("seq_pc_h", pc, 32'd8);
    chk("seq_inst_h", inst, 32'h0);
    step();
    chk("seq_pc_frozen", pc, 32'd8);
    chk("seq_ret_frozen", retired, 32'd3);
  endtask

  task automatic test_jump();
    load_word(0, 32'h0800_0003);
    load_word(3, HALT);
    do_reset();
    start_run();
    chk("jmp_pc0", pc, 32'd0);
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("jmp_pc1", pc, 32'd12);
    chk("jmp_inst1", inst, HALT);
    step();
    chk("jmp_halted", {31'b0, halted}, 32'd1);
    chk("jmp_retired", retired, 32'd2);
    chk("jmp_pc_h", pc, 32'd12);
    // Jump to the top word, then fall through past it: index wraps, pc does not.
    load_word(0, 32'h0BFF_FFFF);
    load_word(63, 32'h2008_0001);
    do_reset();
    start_run();
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("wrap_pc_top", pc, 32'h0FFF_FFFC);
    chk("wrap_inst_top", inst, 32'h2008_0001);
    step();
    chk("wrap_pc_next", pc, 32'h1000_0000);
    chk("wrap_inst_next", inst, 32'h0BFF_FFFF);
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("wrap_pc_region", pc, 32'h1FFF_FFFC);
  endtask

  task automatic test_branch();
    load_word(0, 32'h1000_0001);
    load_word(1, HALT);
    load_word(2, HALT);
    do_reset();
    start_run();
    branch = 1'b1; zero = 1'b1;
    step();
    branch = 1'b0; zero = 1'b0;
    chk("br_taken_pc", pc, 32'd8);
    step();
    chk("br_taken_ret", retired, 32'd2);
    chk("br_taken_halt", {31'b0, halted}, 32'd1);
    do_reset();
    start_run();
    branch = 1'b1; zero = 1'b0;
    step();
    branch = 1'b0;
    chk("br_not_pc", pc, 32'd4);
    // Backward branch: offset -2 words from pc+4 at word 1 lands on word 0.
    load_word(0, 32'h2008_0001);
    load_word(1, 32'h1000_FFFE);
    do_reset();
    start_run();
    step();
    chk("br_back_pc1", pc, 32'd4);
    branch = 1'b1; zero = 1'b1;
    step();
    branch = 1'b0; zero = 1'b0;
    chk("br_back_pc0", pc, 32'd0);
  endtask

  task automatic test_stall();
    load_word(0, 32'h2008_0005);
    load_word(1, 32'h2009_0003);
    load_word(2, HALT);
    do_reset();
    start_run();
    step();
    chk("stall_pc_pre", pc, 32'd4);
    stall = 1'b1;
    jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'd4);
      chk("stall_ret", retired, 32'd1);
    end
    jump = 1'b0;
    stall = 1'b0;
    step();
    chk("stall_release_pc", pc, 32'd8);
    chk("stall_release_ret", retired, 32'd2);
    stall = 1'b1;
    step();
    chk("stall_halt_hold", {31'b0, halted}, 32'd0);
    chk("stall_halt_ret", retired, 32'd2);
    stall = 1'b0;
    step();
    chk("stall_then_halt", {31'b0, halted}, 32'd1);
    chk("stall_then_ret", retired, 32'd3);
  endtask

  task automatic test_reset_midrun();
    do_reset();
    start_run();
    step();
    step();
    chk("mid_pc_pre", pc, 32'd8);
    chk("mid_ret_pre", retired, 32'd2);
    rst = 1'b0;
    #2;
    chk("mid_pc", pc, 32'd0);
    chk("mid_ret", retired, 32'd0);
    chk("mid_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_inst", inst, 32'h0);
    rst = 1'b1;
    step();
    chk("mid_idle_valid", {31'b0, inst_valid}, 32'd0);
    start_run();
    chk("mid_restart_pc", pc, 32'd0);
    chk("mid_restart_inst", inst, 32'h2008_0005);
  endtask

  task automatic test_immunity();
    do_reset();
    jump = 1'b1;
    step();
    step();
    jump = 1'b0;
    chk("imm_idle_pc", pc, 32'd0);
    chk("imm_idle_valid", {31'b0, inst_valid}, 32'd0);
    start_run();
    step();
    step();
    step();
    chk("imm_halted", {31'b0, halted}, 32'd1);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("imm_halt_start", {31'b0, halted}, 32'd1);
    chk("imm_halt_pc", pc, 32'd8);
    load_word(0, 32'h1234_5678);
    chk("imm_halt_after_ld", {31'b0, halted}, 32'd1);
    do_reset();
    start_run();
    chk("imm_readback", inst, 32'h1234_5678);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
    zero = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    step();
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall();
    test_reset_midrun();
    test_immunity();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch unit feeding the single-cycle control decoder. Holds the program counter and a loadable instruction memory, and presents the current instruction word on `inst`. Consumes the decoder's `jump`/`branch` outputs and the ALU `zero` flag to select the next PC. Adds a start/halt state machine, a stall input and a retired-instruction counter so benches can run programs to completion.

## Interface
- `ADDR_WIDTH`, 6: word-address bits of instruction memory (2^ADDR_WIDTH words).
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `HALT_INST`, 32'h0000_000C: instruction word (syscall) that halts fetch.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  leave IDLE and begin fetching.
- `stall`  in  1  hold PC and counter this cycle.
- `jump`  in  1  decoder: current inst is a jump.
- `branch`  in  1  decoder: current inst is a conditional branch.
- `zero`  in  1  ALU zero flag for current inst.
- `ld_en`  in  1  instruction-memory write enable.
- `ld_addr`  in  ADDR_WIDTH  memory word address for load.
- `ld_data`  in  32  word written on load.
- `inst`  out  32  current instruction; 32'h0 (NOP) when `inst_valid`=0.
- `pc`  out  32  current program counter.
- `inst_valid`  out  1  `inst` is a live fetch (state RUN).
- `halted`  out  1  state HALT.
- `retired`  out  32  count of instructions retired since reset.

## Operation
- Memory: 2^ADDR_WIDTH x 32, combinational read at index `pc[ADDR_WIDTH+1:2]`; synchronous write when `ld_en`=1, in any state. Not cleared by reset; contents retained through reset.
- PC bits [1:0] are ignored for indexing; the index wraps modulo memory size while `pc` itself stays full 32-bit.
- `inst` = `inst_valid` ? mem[index] : 32'h0.
- States:
  - IDLE (reset state): `inst_valid`=0, `halted`=0, PC held. `start`=1 moves to RUN on the next edge.
  - RUN: `inst_valid`=1. On each edge with `stall`=0, `retired` increments. Either PC <= next_pc, or, if `inst`==HALT_INST, PC is held and the state moves to HALT. With `stall`=1, nothing changes.
  - HALT: `inst_valid`=0, `halted`=1, PC and `retired` frozen. `start` is ignored; only reset exits.
- next_pc, in priority order:
  1. `jump`: {pc_plus4[31:28], inst[25:0], 2'b00}.
  2. `branch` & `zero`: pc_plus4 + (sign-extended inst[15:0] << 2).
  3. Otherwise pc_plus4, where pc_plus4 = pc + 4.
- All 32-bit PC arithmetic wraps modulo 2^32; `retired` wraps at 2^32.
- `jump`/`branch`/`zero` are sampled only in RUN with `stall`=0; they are ignored elsewhere.
- A load to the address currently fetched is visible on `inst` after that edge.

## Timing
- Reset (asserted, asynchronous): immediately `pc`=RESET_PC, `retired`=0, `inst_valid`=0, `halted`=0, `inst`=0, state IDLE. This holds mid-run as well; memory is untouched.
- Reset release: the first edge with `rst`=1 can act on `start`.
- `start` sampled in IDLE: RUN and the first valid `inst` appear after that edge (1-cycle latency).
- Next-PC decision is combinational from the current `inst` through the decoder; PC updates on the same edge (one instruction per cycle, no bubbles).
- Halt: the edge that retires HALT_INST sets `halted`=1 and `inst_valid`=0 for the following cycle. HALT_INST counts as retired.
- `stall` and HALT_INST together: the stall wins; no transition.
- Jump/branch encoding the halt word: halt has priority (HALT_INST is never a jump or branch in practice).

## Test plan
- Sequential: load 0x20080005 @0, 0x20090003 @1, 0x0000000C @2; `start` -> `pc` 0,4,8 on consecutive cycles; then `halted`=1, `retired`=3, `pc`=8, `inst`=0.
- Jump: 0x08000003 @0, HALT_INST @3, `jump`=1 driven for word 0 -> `pc` 0 then 12; halt with `retired`=2.
- Branch: 0x10000001 @0 with `branch`=1. With `zero`=1 -> `pc` 0 then 8. Repeat with `zero`=0 -> `pc` 0 then 4.
- Stall: in RUN at `pc`=4, `stall`=1 for 3 cycles -> `pc`=4 and `retired` unchanged; advances on the first unstalled edge.
- Reset mid-run: at `pc`=8, `retired`=2, pulse `rst`=0 between edges -> outputs zero/RESET_PC immediately, state IDLE. Restart re-executes the preserved program from 0.
- Idle/halt immunity: `jump`=1 in IDLE and `start`=1 in HALT -> no PC or state change. `ld_en` write in HALT is succeeded by a readback after reset+start.
